writeback_queue: RTL and testbench

- Writeback-side counterpart of the decode stage: it is the writer into the register file that the decoder reads from.
- Accepts results from execute/memory through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains at most one entry per cycle onto the register-file write port (writeEnable/writeAddress/dataToSave).
- Reports per-operand pending hazards, with optional forwarding, for the decoder's reg1Address/reg2Address.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/writeback_queue_if.sv | 41 ++++
 rtl/wbq_match.sv | 45 ++++
 rtl/writeback_queue.sv | 85 ++++++++
 tb/tb_writeback_queue.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the decode stage and the writeback queue.
//   WIDTH        : data width of results and register contents
//   ADDRESSWIDTH : register address width (2**ADDRESSWIDTH registers)
//   wb_entry_t   : one queued register-file write (valid, address, data)
package pipeline_pkg;
    localparam int WIDTH = 32;
    localparam int ADDRESSWIDTH = 3;

    typedef struct packed {
        logic                    valid;
        logic [ADDRESSWIDTH-1:0] address;
        logic [WIDTH-1:0]        data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Bus between the writeback queue and its neighbours.
//   result*      : valid/ready channel from execute/memory into the queue
//   drainStall   : holds off register-file writes
//   writeEnable, writeAddress, dataToSave : register-file write port
//   reg1/reg2*   : decoder operand hazard lookup (address in, pending/forward out)
//   count        : queue occupancy, 0..DEPTH
// master = producer/decoder side, slave = the queue.
interface writeback_queue_if #(parameter int PTRWIDTH = 2);
    import pipeline_pkg::*;

    logic                    resultValid;
    logic                    resultReady;
    logic                    resultWrites;
    logic [ADDRESSWIDTH-1:0] resultAddress;
    logic [WIDTH-1:0]        resultData;
    logic                    drainStall;
    logic                    writeEnable;
    logic [ADDRESSWIDTH-1:0] writeAddress;
    logic [WIDTH-1:0]        dataToSave;
    logic [ADDRESSWIDTH-1:0] reg1Address;
    logic [ADDRESSWIDTH-1:0] reg2Address;
    logic                    reg1Pending;
    logic                    reg2Pending;
    logic [WIDTH-1:0]        reg1Forward;
    logic [WIDTH-1:0]        reg2Forward;
    logic [PTRWIDTH:0]       count;

    modport master (
        output resultValid, resultWrites, resultAddress, resultData, drainStall,
               reg1Address, reg2Address,
        input  resultReady, writeEnable, writeAddress, dataToSave,
               reg1Pending, reg2Pending, reg1Forward, reg2Forward, count
    );

    modport slave (
        input  resultValid, resultWrites, resultAddress, resultData, drainStall,
               reg1Address, reg2Address,
        output resultReady, writeEnable, writeAddress, dataToSave,
               reg1Pending, reg2Pending, reg1Forward, reg2Forward, count
    );
endinterface

// File: rtl/wbq_match.sv
// Combinational lookup of one register address against an age-ordered entry
// array (index 0 oldest, last index youngest).
//   entries : age-ordered queued writes
//   address : register being looked up
//   pending : some valid entry targets address
//   forward : data of the youngest matching entry (0 without WBQ_FORWARDING_EN)
// Optional feature macro: WBQ_FORWARDING_EN builds the forwarding mux.
module wbq_match
    import pipeline_pkg::*;
#(
    parameter int ENTRIES = 5
) (
    input  wb_entry_t               entries [ENTRIES],
    input  logic [ADDRESSWIDTH-1:0] address,
    output logic                    pending,
    output logic [WIDTH-1:0]        forward
);

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries[i].valid && (entries[i].address == address)) pending = 1'b1;
        end
    end

`ifdef WBQ_FORWARDING_EN
    // Ascending scan: the last (youngest) match overrides older ones.
    always_comb begin
        forward = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries[i].valid && (entries[i].address == address)) forward = entries[i].data;
        end
    end
`else
    logic unused_data;

    always_comb begin
        unused_data = 1'b0;
        for (int i = 0; i < ENTRIES; i++) unused_data = unused_data ^ (^entries[i].data);
    end

    assign forward = '0;
`endif

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO between execute/memory and the register file.
//   clock : single clock, posedge
//   reset : synchronous, active low
//   bus   : writeback_queue_if.slave (result channel, write port, hazard lookup, count)
// Parameters: DEPTH (power of two, >= 2), PTRWIDTH = log2(DEPTH).
// Optional feature macro: WBQ_FORWARDING_EN (see wbq_match).
module writeback_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTRWIDTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    writeback_queue_if.slave  bus
);

    wb_entry_t             entries [DEPTH];
    wb_entry_t             ordered [DEPTH+1];
    logic [PTRWIDTH-1:0]   head;
    logic [PTRWIDTH-1:0]   tail;
    logic [PTRWIDTH:0]     occupancy;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Full blocks acceptance even when a pop happens in the same cycle.
    assign full = (occupancy == (PTRWIDTH+1)'(DEPTH));
    assign push = bus.resultValid && !full && bus.resultWrites;
    assign pop  = (occupancy != '0) && !bus.drainStall;

    assign bus.resultReady = !full;
    assign bus.count       = occupancy;

    always_ff @(posedge clock) begin
        if (!reset) begin
            head            <= '0;
            tail            <= '0;
            occupancy       <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            bus.writeEnable <= 1'b0;
            bus.writeAddress <= '0;
            bus.dataToSave  <= '0;
        end else begin
            // push and pop never address the same slot: that needs head == tail
            // with a non-zero count, which is the full state where push is blocked.
            if (push) begin
                entries[tail] <= '{valid: 1'b1, address: bus.resultAddress, data: bus.resultData};
                tail          <= tail + PTRWIDTH'(1);
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTRWIDTH'(1);
                bus.writeEnable     <= 1'b1;
                bus.writeAddress    <= entries[head].address;
                bus.dataToSave      <= entries[head].data;
            end else begin
                bus.writeEnable <= 1'b0;
            end
            occupancy <= occupancy + (PTRWIDTH+1)'(push) - (PTRWIDTH+1)'(pop);
        end
    end

    // The entry on the write port is not in the register file until the falling
    // edge, so it still counts as a hazard; it is the oldest in the lookup.
    always_comb begin
        ordered[0] = '{valid: bus.writeEnable, address: bus.writeAddress, data: bus.dataToSave};
        for (int i = 0; i < DEPTH; i++) ordered[i+1] = entries[head + PTRWIDTH'(i)];
    end

    wbq_match #(.ENTRIES(DEPTH+1)) u_match1 (
        .entries (ordered),
        .address (bus.reg1Address),
        .pending (bus.reg1Pending),
        .forward (bus.reg1Forward)
    );

    wbq_match #(.ENTRIES(DEPTH+1)) u_match2 (
        .entries (ordered),
        .address (bus.reg2Address),
        .pending (bus.reg2Pending),
        .forward (bus.reg2Forward)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a write-order scoreboard and an
// occupancy model.
module tb_writeback_queue;
    import pipeline_pkg::*;

    localparam int DEPTH    = 4;
    localparam int PTRWIDTH = 2;

    typedef struct packed {
        logic [ADDRESSWIDTH-1:0] address;
        logic [WIDTH-1:0]        data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    writeback_queue_if #(.PTRWIDTH(PTRWIDTH)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .PTRWIDTH(PTRWIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    wr_t             sb [$];
    int              vectors     = 0;
    int              miscompares = 0;
    int              exp_count   = 0;
    logic [WIDTH-1:0] regfile [2**ADDRESSWIDTH];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [ADDRESSWIDTH-1:0] a,
                         input logic [WIDTH-1:0] d);
        bus.resultValid   = v;
        bus.resultWrites  = w;
        bus.resultAddress = a;
        bus.resultData    = d;
    endtask

    // One clock: model acceptance and drain, then check outputs at the falling edge.
    task automatic step();
        bit  acc;
        bit  pop;
        wr_t e;
        check("ready", 64'(bus.resultReady), 64'(exp_count != DEPTH));
        acc = bus.resultValid && (exp_count != DEPTH) && bus.resultWrites;
        pop = (exp_count != 0) && !bus.drainStall;
        if (acc) sb.push_back('{address: bus.resultAddress, data: bus.resultData});
        @(posedge clock);
        exp_count = exp_count + int'(acc) - int'(pop);
        @(negedge clock);
        if (bus.writeEnable === 1'b1) begin
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write_addr", 64'(bus.writeAddress), 64'(e.address));
                check("write_data", 64'(bus.dataToSave), 64'(e.data));
            end
            regfile[bus.writeAddress] = bus.dataToSave;
        end
        check("count", 64'(bus.count), 64'(exp_count));
    endtask

    task automatic do_reset();
        bus.resultValid = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        exp_count = 0;
    endtask

    initial begin
        for (int i = 0; i < 2**ADDRESSWIDTH; i++) regfile[i] = '0;
        drive(1'b0, 1'b1, '0, '0);
        bus.drainStall  = 1'b0;
        bus.reg1Address = 3'd3;
        bus.reg2Address = 3'd6;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // reset state
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_we", 64'(bus.writeEnable), 64'd0);
        check("rst_waddr", 64'(bus.writeAddress), 64'd0);
        check("rst_wdata", 64'(bus.dataToSave), 64'd0);
        check("rst_pend1", 64'(bus.reg1Pending), 64'd0);
        check("rst_fwd1", 64'(bus.reg1Forward), 64'd0);

        // single push, one-cycle latency
        drive(1'b1, 1'b1, 3'd3, 32'h0000_00AA);
        step();
        drive(1'b0, 1'b1, '0, '0);
        check("single_we_n", 64'(bus.writeEnable), 64'd0);
        check("single_pend_q", 64'(bus.reg1Pending), 64'd1);
        step();
        check("single_we_n1", 64'(bus.writeEnable), 64'd1);
        check("single_pend_present", 64'(bus.reg1Pending), 64'd1);
        step();
        check("single_we_off", 64'(bus.writeEnable), 64'd0);
        check("single_pend_clear", 64'(bus.reg1Pending), 64'd0);

        // fill under stall, reject fifth, then drain in order
        bus.drainStall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, ADDRESSWIDTH'(i), 32'h100 + 32'(i));
            step();
        end
        check("full_ready", 64'(bus.resultReady), 64'd0);
        drive(1'b1, 1'b1, 3'd6, 32'h0000_0666);
        step();
        check("full_reject_pend", 64'(bus.reg2Pending), 64'd0);
        drive(1'b0, 1'b1, '0, '0);
        bus.drainStall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_we", 64'(bus.writeEnable), 64'd1);
        end
        step();
        check("drain_done_we", 64'(bus.writeEnable), 64'd0);

        // duplicate destination, youngest forwarded, last value wins
        bus.drainStall  = 1'b1;
        bus.reg1Address = 3'd5;
        drive(1'b1, 1'b1, 3'd5, 32'h11);
        step();
        drive(1'b1, 1'b1, 3'd5, 32'h22);
        step();
        drive(1'b0, 1'b1, '0, '0);
        check("dup_pend", 64'(bus.reg1Pending), 64'd1);
`ifdef WBQ_FORWARDING_EN
        check("dup_fwd", 64'(bus.reg1Forward), 64'h22);
`else
        check("dup_fwd", 64'(bus.reg1Forward), 64'h0);
`endif
        bus.drainStall = 1'b0;
        step();
        step();
        check("dup_pend_present", 64'(bus.reg1Pending), 64'd1);
        step();
        check("dup_pend_clear", 64'(bus.reg1Pending), 64'd0);
        check("dup_regfile", 64'(regfile[5]), 64'h22);

        // no-write result completes handshake without being stored
        drive(1'b1, 1'b0, 3'd2, 32'hDEAD);
        step();
        drive(1'b0, 1'b1, '0, '0);
        check("nowrite_we", 64'(bus.writeEnable), 64'd0);
        step();
        check("nowrite_we2", 64'(bus.writeEnable), 64'd0);

        // continuous push and pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, ADDRESSWIDTH'(i % 8), 32'h200 + 32'(i));
            step();
        end
        drive(1'b0, 1'b1, '0, '0);
        step();
        step();
        check("stream_empty_we", 64'(bus.writeEnable), 64'd0);

        // reset mid-operation discards queued writes
        bus.drainStall  = 1'b1;
        bus.reg1Address = 3'd1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, ADDRESSWIDTH'(i), 32'h300 + 32'(i));
            step();
        end
        drive(1'b0, 1'b1, '0, '0);
        bus.drainStall = 1'b0;
        do_reset();
        check("midrst_count", 64'(bus.count), 64'd0);
        check("midrst_we", 64'(bus.writeEnable), 64'd0);
        check("midrst_waddr", 64'(bus.writeAddress), 64'd0);
        check("midrst_wdata", 64'(bus.dataToSave), 64'd0);
        check("midrst_pend", 64'(bus.reg1Pending), 64'd0);
        check("midrst_fwd", 64'(bus.reg1Forward), 64'd0);
        repeat (4) step();

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
